// File: rtl/hqm_aw_cdc_toggle_tx_pkg.sv
// Shared types and constants for the source-side toggle CDC transmitter.
package hqm_aw_cdc_toggle_tx_pkg;

    typedef enum logic [1:0] {
        TX_RESYNC   = 2'd0,
        TX_IDLE     = 2'd1,
        TX_WAIT_ACK = 2'd2
    } hqm_aw_cdc_tx_state_t;

    // Flop stages on the returning ack; the ack-to-ready latency is this plus one.
    localparam int unsigned SYNC_DEPTH = 2;

endpackage

// File: rtl/hqm_aw_cdc_toggle_tx_sync.sv
// Plain multi-flop synchronizer; deliberately not reset so it settles on the live input.
module hqm_aw_sync
    import hqm_aw_cdc_toggle_tx_pkg::*;
#(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = SYNC_DEPTH
) (
    input  logic             clk,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        stage[0] <= d;
        for (int i = 1; i < DEPTH; i++) begin
            stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];

endmodule

// File: rtl/hqm_aw_cdc_toggle_tx.sv
// Source end of a 2-phase req/ack bundled-data CDC channel: one word in flight,
// data held on flops until the synchronized ack toggle matches the request.
module hqm_aw_cdc_toggle_tx
    import hqm_aw_cdc_toggle_tx_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned TO_WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             req_out,
    output logic [WIDTH-1:0] data_out,
    input  logic             ack_in,
    output logic             busy,
    output logic             to_err,
    input  logic             to_err_clr
);

    localparam logic [TO_WIDTH-1:0] TO_MAX = '1;

    hqm_aw_cdc_tx_state_t state, next_state;
    logic                 ack_sync;
    logic                 ack_match;
    logic                 accept;
    logic                 waiting;
    logic                 to_err_set;
    logic [TO_WIDTH-1:0]  to_cnt, to_cnt_nxt;

    hqm_aw_sync #(
        .WIDTH (1),
        .DEPTH (SYNC_DEPTH)
    ) u_ack_sync (
        .clk (clk),
        .d   (ack_in),
        .q   (ack_sync)
    );

    assign ack_match = (ack_sync == req_out);

    // After reset the far end may still show a stale ack, so RESYNC waits for it to agree with req_out.
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        waiting    = 1'b0;
        to_cnt_nxt = to_cnt;
        to_err_set = 1'b0;
        case (state)
            TX_RESYNC: begin
                waiting = 1'b1;
                if (ack_match) next_state = TX_IDLE;
            end
            TX_IDLE: begin
                if (in_valid && in_ready) begin
                    accept     = 1'b1;
                    next_state = TX_WAIT_ACK;
                end
            end
            TX_WAIT_ACK: begin
                waiting = 1'b1;
                if (ack_match) next_state = TX_IDLE;
            end
            default: next_state = TX_RESYNC;
        endcase

        if (accept || (waiting && next_state == TX_IDLE)) begin
            to_cnt_nxt = '0;
        end else if (waiting && to_cnt != TO_MAX) begin
            to_cnt_nxt = to_cnt + TO_WIDTH'(1);
        end
        to_err_set = waiting && (next_state != TX_IDLE) && (to_cnt_nxt == TO_MAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= TX_RESYNC;
            req_out  <= 1'b0;
            data_out <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            to_cnt   <= '0;
            to_err   <= 1'b0;
        end else begin
            state    <= next_state;
            in_ready <= (next_state == TX_IDLE);
            busy     <= (next_state != TX_IDLE);
            to_cnt   <= to_cnt_nxt;
            if (accept) begin
                data_out <= in_data;
                req_out  <= ~req_out;
            end
            if (to_err_set) begin
                to_err <= 1'b1;
            end else if (to_err_clr) begin
                to_err <= 1'b0;
            end
        end
    end

    a_data_stable: assert property (@(posedge clk) disable iff (rst)
        (state == TX_WAIT_ACK) |=> $stable(data_out))
        else $error("data_out changed while waiting for ack");

    // An ack toggle with no request outstanding is a far-end protocol error; the FSM ignores it.
    a_no_stray_ack: assert property (@(posedge clk) disable iff (rst)
        (state == TX_IDLE) |-> (ack_sync == req_out))
        else $warning("stray ack toggle while idle");

endmodule
